// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog control front end.
//  - Register byte addresses; only the low 16 address bits are decoded.
//  - The request/response FSM state type.
//  - The default number of cycles wdt_live is held per kick.
package wdt_pkg;

  localparam logic [15:0] WDT_ADDR_EN     = 16'h0100;
  localparam logic [15:0] WDT_ADDR_LIVE   = 16'h0200;
  localparam logic [15:0] WDT_ADDR_TOCNT  = 16'h0300;
  localparam logic [15:0] WDT_ADDR_STATUS = 16'h0400;

  // wdt_live must stay high for at least two cycles so the watchdog's
  // input register always sees it.
  localparam int KICK_HOLD_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } wdt_state_e;

endpackage

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: memory-mapped control front end for the watchdog counter.
//  Decodes single-beat register requests, drives the watchdog's WDEN,
//  WDLIVE and WTOCNT inputs, issues fixed-length kicks, locks the timeout
//  value while enabled and turns the WTO level into a sticky interrupt.
//
// Ports
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active low
//  req_valid  in   1       request valid
//  req_ready  out  1       request accepted when req_valid & req_ready
//  req_write  in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  register byte address (low 16 bits decoded)
//  req_wdata  in   32      write data
//  rsp_valid  out  1       one-cycle response pulse, one cycle after accept
//  rsp_rdata  out  32      read data, zero unless rsp_valid
//  rsp_err    out  1       error flag, valid with rsp_valid
//  wdt_en     out  1       watchdog WDEN
//  wdt_live   out  1       watchdog WDLIVE (kick)
//  wdt_tocnt  out  CNT_W   watchdog WTOCNT
//  wdt_to     in   1       watchdog WTO level
//  irq_wto    out  1       sticky timeout interrupt
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 32,
  parameter int KICK_HOLD = KICK_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              wdt_en,
  output logic              wdt_live,
  output logic [CNT_W-1:0]  wdt_tocnt,
  input  logic              wdt_to,
  output logic              irq_wto
);

  localparam int KW = $clog2(KICK_HOLD + 1);

  wdt_state_e        state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  logic [CNT_W-1:0]  tocnt_q, tocnt_d;
  logic [KW-1:0]     kick_cnt_q, kick_cnt_d;
  logic              sticky_q, sticky_d;

  logic              accept;
  logic              kick;
  logic              sticky_clr;
  logic              live_now;
  logic [15:0]       addr_lo;

  // Ready is gated by rst directly so no request can be taken while the
  // block is held in reset, even before the first reset edge.
  assign req_ready = rst && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_lo   = req_addr[15:0];
  assign live_now  = (kick_cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rdata_d     = '0;
    err_d       = 1'b0;
    en_d        = en_q;
    tocnt_d     = tocnt_q;
    kick        = 1'b0;
    sticky_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          case (addr_lo)
            WDT_ADDR_EN: begin
              if (req_write) begin
                en_d = req_wdata[0];
                // Enabling kicks the core so its count restarts from 0.
                kick = req_wdata[0] && !en_q;
              end else begin
                rdata_d = {31'b0, en_q};
              end
            end
            WDT_ADDR_LIVE: begin
              if (req_write) begin
                kick = req_wdata[0];
              end else begin
                rdata_d = {31'b0, live_now};
              end
            end
            WDT_ADDR_TOCNT: begin
              if (req_write) begin
                // Timeout value is locked while the watchdog runs.
                if (en_q) begin
                  err_d = 1'b1;
                end else begin
                  tocnt_d = CNT_W'(req_wdata);
                end
              end else begin
                rdata_d = 32'(tocnt_q);
              end
            end
            WDT_ADDR_STATUS: begin
              if (req_write) begin
                sticky_clr = req_wdata[0];
              end else begin
                rdata_d = {31'b0, sticky_q};
              end
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A kick reloads the hold counter, so a kick during a hold extends it
    // without a gap; otherwise the counter runs down on its own.
    if (kick) begin
      kick_cnt_d = KW'(KICK_HOLD);
    end else if (kick_cnt_q != '0) begin
      kick_cnt_d = kick_cnt_q - KW'(1);
    end else begin
      kick_cnt_d = kick_cnt_q;
    end

    // A timeout seen in the same cycle as a clear wins.
    sticky_d = wdt_to || (sticky_q && !sticky_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      tocnt_q     <= '0;
      kick_cnt_q  <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      en_q        <= en_d;
      tocnt_q     <= tocnt_d;
      kick_cnt_q  <= kick_cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  // A response that is pending when reset is asserted is suppressed at
  // once rather than at the next clock edge.
  assign rsp_valid = rsp_valid_q && rst;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

  assign wdt_en    = en_q;
  assign wdt_live  = live_now;
  assign wdt_tocnt = tocnt_q;
  assign irq_wto   = sticky_q;

endmodule
